// File: rtl/aes_key_expand_iter.sv
`default_nettype none
// =============================================================================
// Module   : aes_key_expand_iter
// Brief    : Iterative AES-128/192/256 key schedule, one 32-bit word per clock,
//            with an indexed round-key read port into the internal word buffer.
// Revision : 1.0
// =============================================================================
module aes_key_expand_iter #(
   parameter int MAX_KEY_BITS = 256,
   parameter int RD_LATENCY   = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_Start,
   input  logic [1:0]   i_Key_Len,
   input  logic [255:0] i_Key,
   output logic         o_Busy,
   output logic         o_Done,
   output logic         o_Err,
   output logic         o_Key_Valid,
   output logic [3:0]   o_Num_Rounds,
   input  logic [3:0]   i_Rd_Round,
   output logic [127:0] o_Rd_Key
);

   localparam int c_MAX_NR = (MAX_KEY_BITS >= 256) ? 14 : ((MAX_KEY_BITS >= 192) ? 12 : 10);
   localparam int c_WORDS  = 4 * (c_MAX_NR + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      r_state, w_next_state;
   logic [31:0] r_buf [c_WORDS];
   logic [5:0]  r_idx;
   logic [5:0]  r_last;
   logic [2:0]  r_mod;
   logic [3:0]  r_nk;
   logic [7:0]  r_rcon;
   logic        r_err;
   logic        r_key_valid;
   logic [3:0]  r_num_rounds;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (zero maps to zero), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Start decode
   logic       w_len_ok;
   logic [3:0] w_nk;
   logic [3:0] w_nr;
   logic       w_start_ok;
   logic       w_start_bad;

   always_comb begin
      w_len_ok = 1'b0;
      w_nk     = 4'd4;
      w_nr     = 4'd10;
      case (i_Key_Len)
         2'b00: w_len_ok = 1'b1;
         2'b01: begin
            w_len_ok = (MAX_KEY_BITS >= 192);
            w_nk     = 4'd6;
            w_nr     = 4'd12;
         end
         2'b10: begin
            w_len_ok = (MAX_KEY_BITS >= 256);
            w_nk     = 4'd8;
            w_nr     = 4'd14;
         end
         default: w_len_ok = 1'b0;
      endcase
   end

   assign w_start_ok  = (r_state == IDLE) && i_Start && w_len_ok;
   assign w_start_bad = (r_state == IDLE) && i_Start && !w_len_ok;

   // Word generation: single SubWord path shared by the rotate and the 256-bit mid-step
   logic [5:0]  w_prev_idx;
   logic [5:0]  w_back_idx;
   logic [31:0] w_prev;
   logic [31:0] w_sub_in;
   logic [31:0] w_sub_out;
   logic [31:0] w_t;
   logic [31:0] w_new;
   logic        w_rot_step;
   logic        w_sub_step;
   logic        w_last_word;

   assign w_prev_idx  = r_idx - 6'd1;
   assign w_back_idx  = r_idx - {2'b00, r_nk};
   assign w_prev      = r_buf[w_prev_idx];
   assign w_rot_step  = (r_mod == 3'd0);
   assign w_sub_step  = (r_nk == 4'd8) && (r_mod == 3'd4);
   assign w_sub_in    = w_rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign w_sub_out   = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                         sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};
   assign w_t         = w_rot_step ? (w_sub_out ^ {r_rcon, 24'h000000}) :
                        (w_sub_step ? w_sub_out : w_prev);
   assign w_new       = r_buf[w_back_idx] ^ w_t;
   assign w_last_word = (r_idx == r_last);

   always_comb begin
      w_next_state = r_state;
      o_Busy       = 1'b0;
      o_Done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_ok) w_next_state = EXPAND;
         end
         EXPAND: begin
            o_Busy = 1'b1;
            if (w_last_word) w_next_state = DONE;
         end
         DONE: begin
            o_Done       = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_last       <= '0;
         r_mod        <= '0;
         r_nk         <= 4'd4;
         r_rcon       <= 8'h01;
         r_err        <= 1'b0;
         r_key_valid  <= 1'b0;
         r_num_rounds <= '0;
      end else begin
         r_state <= w_next_state;
         r_err   <= w_start_bad;
         if (w_start_ok) begin
            r_idx        <= {2'b00, w_nk};
            r_last       <= {w_nr, 2'b11};
            r_mod        <= '0;
            r_nk         <= w_nk;
            r_rcon       <= 8'h01;
            r_key_valid  <= 1'b0;
            r_num_rounds <= w_nr;
         end else if (r_state == EXPAND) begin
            r_idx <= r_idx + 6'd1;
            if ({1'b0, r_mod} == (r_nk - 4'd1)) r_mod <= '0;
            else                                r_mod <= r_mod + 3'd1;
            if (w_rot_step) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            if (w_last_word) r_key_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < c_WORDS; k++) r_buf[k] <= '0;
      end else if (w_start_ok) begin
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < w_nk) r_buf[k] <= i_Key[255 - 32*k -: 32];
         end
      end else if (r_state == EXPAND) begin
         r_buf[r_idx] <= w_new;
      end
   end

   assign o_Err        = r_err;
   assign o_Key_Valid  = r_key_valid;
   assign o_Num_Rounds = r_num_rounds;

   // Read port: rounds beyond the buffer depth are hard zero
   logic [127:0] w_round [16];
   logic [127:0] w_rd_key;

   generate
      for (genvar r = 0; r < 16; r++) begin : g_round
         if (r <= c_MAX_NR) begin : g_held
            assign w_round[r] = {r_buf[4*r], r_buf[4*r+1], r_buf[4*r+2], r_buf[4*r+3]};
         end else begin : g_absent
            assign w_round[r] = '0;
         end
      end
   endgenerate

   assign w_rd_key = (i_Rd_Round > r_num_rounds) ? '0 : w_round[i_Rd_Round];

   generate
      if (RD_LATENCY == 1) begin : g_rd_reg
         logic [127:0] r_rd_key;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_rd_key <= '0;
            else        r_rd_key <= w_rd_key;
         end
         assign o_Rd_Key = r_rd_key;
      end else begin : g_rd_comb
         assign o_Rd_Key = w_rd_key;
      end
   endgenerate

endmodule
`default_nettype wire
